// File: rtl/fp_mult_ctrl_if.sv
// Operand/result handshake bundle for fp_mult_ctrl.
// The master drives operands and result acceptance; the slave is the controller.
interface fp_mult_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_mult_ctrl.sv
// Multi-cycle IEEE-754 single-precision multiplier using a STEP-bit shift-add significand multiplier.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; otherwise the product is truncated.
module fp_mult_ctrl #(
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mult_ctrl_if.slave bus
);

    localparam int         N_STEPS   = 24 / STEP;
    localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);
    localparam int         PW        = 25 + STEP;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    logic [23:0]       sig_a_q, sig_a_d;
    logic [23:0]       mplr_q, mplr_d;
    logic [47:0]       acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic signed [9:0] exp_q, exp_d;
    logic [31:0]       result_q, result_d;

    logic sign_ab;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sign_ab = a_q[31] ^ b_q[31];
    assign a_zero  = (a_q[30:23] == 8'h00);
    assign b_zero  = (b_q[30:23] == 8'h00);
    assign a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
    assign b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
    assign a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
    assign b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);

    // One shift-add step: add multiplicand * low STEP multiplier bits to the upper half, then shift right.
    logic [PW-1:0] upper_sum;
    assign upper_sum = PW'(acc_q[47:24]) + PW'(sig_a_q) * PW'(mplr_q[STEP-1:0]);

    logic [22:0]       frac_n;
    logic signed [9:0] exp_n;
    logic [31:0]       norm_result;
`ifdef FP_MULT_ROUND_EN
    logic        guard_bit, sticky_bit, round_carry;
    logic [22:0] frac_r;
`else
    logic discard_unused;
    assign discard_unused = ^acc_q[22:0];
`endif

    always_comb begin
        frac_n = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
        exp_n  = acc_q[47] ? exp_q + 10'sd1 : exp_q;
`ifdef FP_MULT_ROUND_EN
        guard_bit  = acc_q[47] ? acc_q[23] : acc_q[22];
        sticky_bit = acc_q[47] ? |acc_q[22:0] : |acc_q[21:0];
        {round_carry, frac_r} = {1'b0, frac_n} + 24'(guard_bit & (sticky_bit | frac_n[0]));
        // A carry out means the significand became 2.0: fraction is already zero, bump the exponent.
        if (round_carry) exp_n = exp_n + 10'sd1;
        frac_n = frac_r;
`endif
        if (exp_n >= 10'sd255)    norm_result = {sign_q, 31'h7F80_0000};
        else if (exp_n <= 10'sd0) norm_result = {sign_q, 31'h0};
        else                      norm_result = {sign_q, exp_n[7:0], frac_n};
    end

    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        sig_a_d  = sig_a_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = sign_ab;
                sig_a_d = {1'b1, a_q[22:0]};
                mplr_d  = {1'b1, b_q[22:0]};
                acc_d   = '0;
                cnt_d   = '0;
                exp_d   = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    result_d = QNAN;
                    state_d  = DONE;
                end else if (a_inf || b_inf) begin
                    result_d = {sign_ab, 31'h7F80_0000};
                    state_d  = DONE;
                end else if (a_zero || b_zero) begin
                    result_d = {sign_ab, 31'h0};
                    state_d  = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = 48'({upper_sum, acc_q[23:0]} >> STEP);
                mplr_d = mplr_q >> STEP;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) state_d = NORM;
            end
            NORM: begin
                result_d = norm_result;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            sig_a_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            sig_a_q  <= sig_a_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_fp_mult_ctrl.sv
// Scoreboard bench for fp_mult_ctrl: directed spec cases, backpressure, mid-operation reset, then random operands.
// Expected products come from an integer reference model; FP_MULT_ROUND_EN selects its rounding mode.
`timescale 1ns/1ps
module tb_fp_mult_ctrl;

    localparam int STEP        = 1;
    localparam int NORMAL_LAT  = 24 / STEP + 3;
    localparam int SPECIAL_LAT = 2;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fp_mult_ctrl_if bus();

    fp_mult_ctrl #(.STEP(STEP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          force_low = 1'b0;
    bit          rand_bp   = 1'b0;
    bit          dir_valid = 1'b0;
    logic [31:0] dir_exp   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference product: exact integer significand product, then normalise and round by remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e, sh;
        logic x_nan, y_nan, x_inf, y_inf;
        longint unsigned p, m;
`ifdef FP_MULT_ROUND_EN
        longint unsigned rem, half;
`endif
        s     = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        x_nan = (ex == 255) && (x[22:0] != 23'h0);
        y_nan = (ey == 255) && (y[22:0] != 23'h0);
        x_inf = (ex == 255) && (x[22:0] == 23'h0);
        y_inf = (ey == 255) && (y[22:0] == 23'h0);
        if (x_nan || y_nan) return 32'h7FC0_0000;
        if ((x_inf && ey == 0) || (y_inf && ex == 0)) return 32'h7FC0_0000;
        if (x_inf || y_inf) return {s, 31'h7F80_0000};
        if (ex == 0 || ey == 0) return {s, 31'h0};
        p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
        e  = ex + ey - 127;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) e++;
        m = p >> sh;
`ifdef FP_MULT_ROUND_EN
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m++;
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e++;
        end
`endif
        if (e >= 255) return {s, 31'h7F80_0000};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 19);
        case (k)
            0:       v[30:23] = 8'h00;
            1:       v[30:23] = 8'hFF;
            2:       v[30:0]  = 31'h7F80_0000;
            3:       begin v[30:23] = 8'($urandom_range(110, 144)); v[15:0] = 16'h0; end
            4, 5:    v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(96, 158));
        endcase
        return v;
    endfunction

    // Result consumer: ready held, free-running, or randomly throttled.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (force_low)    bus.out_ready = 1'b0;
            else if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            else              bus.out_ready = 1'b1;
        end
    end

    // Monitor: records accepted operands, then checks latency, stability and value of each result.
    initial begin : monitor
        exp_t e;
        bit prev_ov;
        logic [31:0] prev_res;
        prev_ov  = 1'b0;
        prev_res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                check("ready_is_not_busy", 32'(bus.in_ready), 32'(!bus.busy));
                if (bus.in_valid && bus.in_ready) begin
                    e.res     = dir_valid ? dir_exp : ref_mul(bus.a, bus.b);
                    e.lat     = is_special(bus.a, bus.b) ? SPECIAL_LAT : NORMAL_LAT;
                    e.acc_cyc = cyc + 1;
                    dir_valid = 1'b0;
                    exp_q.push_back(e);
                end
                if (bus.out_valid) begin
                    check("output_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (prev_ov) check("result_stable", bus.result, prev_res);
                    else if (exp_q.size() != 0)
                        check("latency", 32'(cyc + 1 - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                    if (bus.out_ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("result", bus.result, e.res);
                    end
                end
                prev_ov  = bus.out_valid && !bus.out_ready;
                prev_res = bus.result;
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        check("accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and scrambles the inputs (with in_valid pulses) until the controller is idle.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] req, input bit use_req);
        int n;
        dir_exp      = req;
        dir_valid    = use_req;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        wait_accept();
        n = 0;
        while (bus.busy && n < 500) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("op_complete", 32'(bus.busy), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);
`ifdef FP_MULT_ROUND_EN
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b1);
`else
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 1'b1);
`endif
        run_op(32'h0000_0000, 32'hC0A0_0000, 32'h8000_0000, 1'b1);
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1);
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1);

        // Backpressure: result must hold with in_ready low while in_valid pulses.
        force_low    = 1'b1;
        dir_exp      = 32'h40C0_0000;
        dir_valid    = 1'b1;
        bus.a        = 32'h4000_0000;
        bus.b        = 32'h4040_0000;
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check("bp_reached_done", 32'(bus.out_valid), 32'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
            check("bp_hold_result", bus.result, 32'h40C0_0000);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        force_low    = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_released", 32'(bus.busy), 32'd0);

        // Reset in the middle of MUL discards the operation.
        dir_valid    = 1'b0;
        bus.a        = 32'h3FC0_0000;
        bus.b        = 32'h3FC0_0000;
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_mul_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_result", bus.result, 32'h0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);

        rand_bp = 1'b1;
        repeat (300) run_op(rand_operand(), rand_operand(), 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
